// File: rtl/kbd_axil_pkg.sv
// Purpose: shared constants and state types for the keyboard AXI4-Lite register block.
// Contents: register offsets (addr[3:2]), CTRL/STATUS/DATA bit positions,
//           AXI response code, write/read FSM state enums.
package kbd_axil_pkg;

    // Register offsets, decoded from addr[3:2]
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DATA    = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    // CTRL bits
    localparam int unsigned CTRL_ENABLE_BIT   = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT   = 1;
    localparam int unsigned CTRL_FIFO_CLR_BIT = 2;

    // STATUS bits
    localparam int unsigned STAT_EMPTY_BIT = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_OVF_BIT   = 2;
    localparam int unsigned STAT_COUNT_LSB = 4;
    localparam int unsigned STAT_COUNT_W   = 4;

    // DATA bits
    localparam int unsigned DATA_VALID_BIT = 31;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

endpackage

// File: rtl/kbd_scan_fifo.sv
// Purpose: synchronous 8-bit scancode FIFO with show-ahead output.
// Ports: i_clk/i_rst (sync active-high), i_push/i_din write side, i_pop read side,
//        i_clr flush (wins over push/pop), o_dout head word (combinational),
//        o_empty/o_full flags, o_count occupancy (0..DEPTH).
module kbd_scan_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [7:0]               i_din,
    input  logic                     i_pop,
    input  logic                     i_clr,
    output logic [7:0]               o_dout,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_dout  = r_mem[r_rptr];
    assign o_count = r_count;

    // A push into a full FIFO is only taken when the head leaves in the same cycle
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage array, no reset needed
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_clr) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/kbd_axil_regs.sv
// Purpose: AXI4-Lite register block for the keyboard peripheral.
// Ports: ACLK/ARESET (sync active-high); AXI4-Lite AW/W/B/AR/R channels;
//        kb_code/kb_valid scancode input strobe; irq level interrupt (registered).
// Map: 0x0 CTRL, 0x4 STATUS, 0x8 DATA (read pops FIFO), 0xC SCRATCH.
module kbd_axil_regs
    import kbd_axil_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH = 32,
    parameter int unsigned C_ADDR_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [C_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                AWPROT,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [C_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [C_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                ARPROT,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [C_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY,
    input  logic [7:0]                kb_code,
    input  logic                      kb_valid,
    output logic                      irq
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Write path state
    w_state_t    r_wstate;
    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;
    logic        r_aw_got;
    logic        r_w_got;
    logic [1:0]  r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    // Read path state
    r_state_t    r_rstate;
    logic        r_arready;
    logic        r_rvalid;
    logic [31:0] r_rdata;

    // Registers
    logic        r_enable;
    logic        r_irq_en;
    logic        r_ovf;
    logic        r_irq;
    logic [31:0] r_scratch;

    // Decode and FIFO wiring
    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_ar_hs;
    logic             w_wr_en;
    logic [1:0]       w_wr_reg;
    logic [31:0]      w_wr_data;
    logic [3:0]       w_wr_strb;
    logic             w_fifo_clr;
    logic             w_ovf_clr;
    logic             w_ovf_set;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_rd_val;
    logic [7:0]       w_fifo_dout;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_unused;

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = AXI_RESP_OKAY;
    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RDATA   = r_rdata;
    assign RRESP   = AXI_RESP_OKAY;
    assign irq     = r_irq;

    // Protection bits and byte-lane address bits carry no meaning here
    assign w_unused = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    // Write decode: a channel captured this cycle is used directly so the
    // update lands in the same cycle as the later handshake
    always_comb begin
        w_aw_hs    = AWVALID & r_awready;
        w_w_hs     = WVALID & r_wready;
        w_wr_reg   = r_aw_got ? r_awaddr : AWADDR[3:2];
        w_wr_data  = r_w_got ? r_wdata : WDATA;
        w_wr_strb  = r_w_got ? r_wstrb : WSTRB;
        w_wr_en    = (r_wstate == W_IDLE) & (r_aw_got | w_aw_hs) & (r_w_got | w_w_hs);
        w_fifo_clr = w_wr_en & (w_wr_reg == REG_CTRL) & w_wr_strb[0]
                     & w_wr_data[CTRL_FIFO_CLR_BIT];
        w_ovf_clr  = w_wr_en & (w_wr_reg == REG_STATUS) & w_wr_strb[0]
                     & w_wr_data[STAT_OVF_BIT];
        w_ar_hs    = ARVALID & r_arready;
        w_pop      = w_ar_hs & (ARADDR[3:2] == REG_DATA) & ~w_fifo_empty;
        w_push     = kb_valid & r_enable;
        // A flushed push is discarded, not counted as an overflow
        w_ovf_set  = w_push & w_fifo_full & ~w_pop & ~w_fifo_clr;
    end

    // Read data mux, sampled at the AR handshake
    always_comb begin
        w_rd_val = '0;
        case (ARADDR[3:2])
            REG_CTRL: begin
                w_rd_val[CTRL_ENABLE_BIT] = r_enable;
                w_rd_val[CTRL_IRQ_EN_BIT] = r_irq_en;
            end
            REG_STATUS: begin
                w_rd_val[STAT_EMPTY_BIT] = w_fifo_empty;
                w_rd_val[STAT_FULL_BIT]  = w_fifo_full;
                w_rd_val[STAT_OVF_BIT]   = r_ovf;
                w_rd_val[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(w_fifo_count);
            end
            REG_DATA: begin
                if (!w_fifo_empty) begin
                    w_rd_val[DATA_VALID_BIT] = 1'b1;
                    w_rd_val[7:0]            = w_fifo_dout;
                end
            end
            REG_SCRATCH: w_rd_val = r_scratch;
            default:     w_rd_val = '0;
        endcase
    end

    // Write FSM: one-cycle ready pulse per channel, response held until BREADY
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_got <= 1'b1;
                        r_awaddr <= AWADDR[3:2];
                    end
                    if (w_w_hs) begin
                        r_w_got <= 1'b1;
                        r_wdata <= WDATA;
                        r_wstrb <= WSTRB;
                    end
                    r_awready <= AWVALID & ~r_aw_got & ~r_awready;
                    r_wready  <= WVALID & ~r_w_got & ~r_wready;
                    if (w_wr_en) begin
                        r_wstate  <= W_RESP;
                        r_bvalid  <= 1'b1;
                        r_aw_got  <= 1'b0;
                        r_w_got   <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                    end
                end
                W_RESP: begin
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    if (BREADY) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read FSM: data captured (and FIFO popped) at the AR handshake
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= ARVALID & ~r_arready;
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_rdata   <= w_rd_val;
                        r_rvalid  <= 1'b1;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    r_arready <= 1'b0;
                    if (RREADY) begin
                        r_rvalid <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // Register file, sticky overflow (set beats W1C) and interrupt
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_enable  <= 1'b0;
            r_irq_en  <= 1'b0;
            r_scratch <= '0;
            r_ovf     <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr_en && w_wr_reg == REG_CTRL && w_wr_strb[0]) begin
                r_enable <= w_wr_data[CTRL_ENABLE_BIT];
                r_irq_en <= w_wr_data[CTRL_IRQ_EN_BIT];
            end
            if (w_wr_en && w_wr_reg == REG_SCRATCH) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_wr_strb[b]) begin
                        r_scratch[8*b +: 8] <= w_wr_data[8*b +: 8];
                    end
                end
            end
            r_ovf <= w_ovf_set | (r_ovf & ~w_ovf_clr);
            r_irq <= r_irq_en & r_enable & ~w_fifo_empty;
        end
    end

    kbd_scan_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (ACLK),
        .i_rst   (ARESET),
        .i_push  (w_push),
        .i_din   (kb_code),
        .i_pop   (w_pop),
        .i_clr   (w_fifo_clr),
        .o_dout  (w_fifo_dout),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

endmodule

// File: tb/tb_kbd_axil_regs.sv
// Purpose: scoreboard bench for kbd_axil_regs. Stimulus tasks push expected
// B/R responses into queues; a negedge monitor pops and compares on each handshake.
module tb_kbd_axil_regs;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  AWADDR;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  ARADDR;
    logic [2:0]  ARPROT;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic [7:0]  kb_code;
    logic        kb_valid;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0]  bq[$];
    logic [31:0] rq[$];

    always #5 ACLK = ~ACLK;

    kbd_axil_regs #(
        .C_DATA_WIDTH (32),
        .C_ADDR_WIDTH (4),
        .FIFO_DEPTH   (8)
    ) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .AWADDR   (AWADDR),
        .AWPROT   (AWPROT),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .ARADDR   (ARADDR),
        .ARPROT   (ARPROT),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .kb_code  (kb_code),
        .kb_valid (kb_valid),
        .irq      (irq)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void tmo(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no handshake within cycle budget", name);
    endfunction

    // Scoreboard monitor
    always @(negedge ACLK) begin
        if (!ARESET && BVALID && BREADY) begin
            if (bq.size() == 0) chk("b_unexpected", 32'(bq.size()), 32'd1);
            else                chk("bresp", 32'(BRESP), 32'(bq.pop_front()));
        end
        if (!ARESET && RVALID && RREADY) begin
            if (rq.size() == 0) chk("r_unexpected", 32'(rq.size()), 32'd1);
            else begin
                chk("rdata", RDATA, rq.pop_front());
                chk("rresp", 32'(RRESP), 32'd0);
            end
        end
    end

    task automatic kb_push(input logic [7:0] c);
        kb_code  = c;
        kb_valid = 1'b1;
        @(posedge ACLK); #1;
        kb_valid = 1'b0;
    endtask

    // AW and W presented together; optional kb strobe in the handshake cycle
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int kb = -1);
        int n;
        n = 0;
        bq.push_back(2'b00);
        AWADDR = a; WDATA = d; WSTRB = s;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        do begin @(negedge ACLK); n++; end while (!(AWREADY && WREADY) && n < 50);
        if (!(AWREADY && WREADY)) begin
            tmo("write_addr_data");
            AWVALID = 1'b0; WVALID = 1'b0;
            return;
        end
        if (kb >= 0) begin kb_code = 8'(kb); kb_valid = 1'b1; end
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0; kb_valid = 1'b0;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!BVALID && n < 50);
        if (!BVALID) begin tmo("write_resp"); return; end
        @(posedge ACLK); #1;
    endtask

    task automatic axi_read(input logic [3:0] a, input logic [31:0] exp,
                            input int kb = -1, input bit chk_irq = 1'b0);
        int n;
        n = 0;
        rq.push_back(exp);
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
        do begin @(negedge ACLK); n++; end while (!ARREADY && n < 50);
        if (!ARREADY) begin tmo("read_addr"); ARVALID = 1'b0; return; end
        if (kb >= 0) begin kb_code = 8'(kb); kb_valid = 1'b1; end
        @(posedge ACLK); #1;
        ARVALID = 1'b0; kb_valid = 1'b0;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!RVALID && n < 50);
        if (!RVALID) begin tmo("read_data"); return; end
        if (chk_irq) chk("irq_held_after_pop", 32'(irq), 32'd1);
        @(posedge ACLK); #1;
        if (chk_irq) begin
            @(negedge ACLK);
            chk("irq_fall_after_pop", 32'(irq), 32'd0);
            @(posedge ACLK); #1;
        end
    endtask

    // One channel presented 5 cycles before the other; BREADY held low 3 cycles
    task automatic split_write(input bit aw_first, input logic [31:0] d);
        int aw_c, w_c, b_c, held, last;
        aw_c = -1; w_c = -1; b_c = -1; held = 0;
        bq.push_back(2'b00);
        AWADDR = 4'hC; WDATA = d; WSTRB = 4'hF; BREADY = 1'b0;
        if (aw_first) AWVALID = 1'b1; else WVALID = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge ACLK);
            if (AWVALID && AWREADY) aw_c = c;
            if (WVALID && WREADY) w_c = c;
            if (BVALID && b_c < 0) b_c = c;
            if (BVALID && BREADY) break;
            if (BVALID) held++;
            @(posedge ACLK); #1;
            if (aw_c == c) AWVALID = 1'b0;
            if (w_c == c) WVALID = 1'b0;
            if (c == 5) begin
                if (aw_first) WVALID = 1'b1; else AWVALID = 1'b1;
            end
            if (held == 3) BREADY = 1'b1;
        end
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        last = (aw_c > w_c) ? aw_c : w_c;
        chk(aw_first ? "aw_first_late_hs" : "w_first_late_hs", 32'(last), 32'd7);
        chk(aw_first ? "aw_first_bvalid" : "w_first_bvalid", 32'(b_c - last), 32'd1);
        chk("bvalid_held_3", 32'(held), 32'd3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET = 1'b1;
        AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
        kb_code = '0; kb_valid = 1'b0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_ready_valid_irq", 32'({AWREADY, WREADY, BVALID, ARREADY, RVALID, irq}), 32'd0);
        chk("rst_resp", 32'({BRESP, RRESP}), 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;

        // Basic write/readback
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h4, 32'h2, 4'hF);
        axi_write(4'h8, 32'h3, 4'hF);
        axi_write(4'hC, 32'h4, 4'hF);
        axi_read(4'h0, 32'h1);
        axi_read(4'h4, 32'h1);
        axi_read(4'h8, 32'h0);
        axi_read(4'hC, 32'h4);

        // Channel ordering and B hold
        split_write(1'b1, 32'hDEAD_BEEF);
        axi_read(4'hC, 32'hDEAD_BEEF);
        split_write(1'b0, 32'h0BAD_F00D);
        axi_read(4'hC, 32'h0BAD_F00D);
        axi_write(4'hC, 32'hFFFF_FFFF, 4'b0010);
        axi_read(4'hC, 32'h0BAD_FF0D);

        // FIFO pop and irq
        axi_write(4'h0, 32'h3, 4'hF);
        @(negedge ACLK);
        chk("irq_idle_empty", 32'(irq), 32'd0);
        @(posedge ACLK); #1;
        kb_push(8'h1C);
        kb_push(8'h32);
        @(negedge ACLK);
        chk("irq_pending", 32'(irq), 32'd1);
        @(posedge ACLK); #1;
        axi_read(4'h8, 32'h8000_001C);
        axi_read(4'h8, 32'h8000_0032, -1, 1'b1);
        axi_read(4'h8, 32'h0);

        // Overflow, W1C, push+pop while full
        axi_write(4'h0, 32'h1, 4'hF);
        for (int i = 0; i < 9; i++) kb_push(8'(8'h10 + i));
        axi_read(4'h4, 32'h86);
        axi_write(4'h4, 32'h4, 4'hF);
        axi_read(4'h4, 32'h82);
        axi_read(4'h8, 32'h8000_0010, 8'h55);
        axi_read(4'h4, 32'h82);

        // fifo_clr, including a push in the clearing cycle
        axi_write(4'h0, 32'h5, 4'hF);
        axi_read(4'h4, 32'h1);
        kb_push(8'hA1);
        kb_push(8'hA2);
        axi_read(4'h4, 32'h20);
        axi_write(4'h0, 32'h5, 4'hF, 8'hA3);
        axi_read(4'h4, 32'h1);
        axi_read(4'h0, 32'h1);

        // Same-register read and write in the same cycle returns the old value
        fork
            axi_write(4'hC, 32'h1234_5678, 4'hF);
            axi_read(4'hC, 32'h0BAD_FF0D);
        join
        axi_read(4'hC, 32'h1234_5678);

        // Reset with B and R both pending
        axi_write(4'h0, 32'h3, 4'hF);
        kb_push(8'h77);
        BREADY = 1'b0; RREADY = 1'b0;
        AWADDR = 4'hC; WDATA = 32'h5555_5555; WSTRB = 4'hF; ARADDR = 4'hC;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        for (int c = 0; c < 20; c++) begin
            logic f_aw, f_w, f_ar;
            @(negedge ACLK);
            if (BVALID && RVALID) break;
            f_aw = AWREADY; f_w = WREADY; f_ar = ARREADY;
            @(posedge ACLK); #1;
            if (f_aw) AWVALID = 1'b0;
            if (f_w)  WVALID  = 1'b0;
            if (f_ar) ARVALID = 1'b0;
        end
        chk("pre_reset_b_r_valid", 32'({BVALID, RVALID}), 32'd3);
        @(posedge ACLK); #1;
        @(negedge ACLK);
        chk("rdata_stable_while_stalled", RDATA, 32'h1234_5678);
        chk("irq_before_reset", 32'(irq), 32'd1);
        @(posedge ACLK); #1;
        ARESET = 1'b1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        chk("mid_reset_valid_ready", 32'({AWREADY, WREADY, BVALID, ARREADY, RVALID}), 32'd0);
        chk("mid_reset_irq", 32'(irq), 32'd0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        BREADY = 1'b1; RREADY = 1'b1;
        axi_read(4'h0, 32'h0);
        axi_read(4'h4, 32'h1);
        axi_read(4'hC, 32'h0);
        kb_push(8'h99);
        axi_read(4'h4, 32'h1);
        axi_write(4'hC, 32'hA5A5_A5A5, 4'hF);
        axi_read(4'hC, 32'hA5A5_A5A5);

        repeat (3) @(posedge ACLK);
        chk("b_queue_drained", 32'(bq.size()), 32'd0);
        chk("r_queue_drained", 32'(rq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
